// File: rtl/epp_clk_gen_pkg.sv
// Shared helpers for the EPD clock generator: default timing and parameter sanity checks.
package epp_clk_gen_pkg;

  localparam int DEF_DIV         = 6;
  localparam int DEF_PHASE       = 3;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_CW          = 16;

  // High-phase length of a divided clock; odd dividers end up low-heavy.
  function automatic int duty_half(input int div);
    return div / 2;
  endfunction

  // True when value v can be held in an unsigned counter of cw bits.
  function automatic bit fits_width(input int v, input int cw);
    if (cw >= 31) return 1'b1;
    return v < (1 << cw);
  endfunction

endpackage

// File: rtl/epp_clk_div.sv
// Integer clock divider with registered clock, rise strobe and optional start delay.
module epp_clk_div
  import epp_clk_gen_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int PHASE = 0,
  parameter int CW    = DEF_CW
) (
  input  logic clk_in1,
  input  logic reset,
  output logic clk_out,
  output logic ce
);

  localparam logic [CW-1:0] TERM = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(duty_half(DIV));
  localparam logic [CW-1:0] PH   = CW'(PHASE);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] dly_reg, dly_next;
  logic          clk_reg, clk_next;
  logic          ce_reg, ce_next;
  logic          run;

  // The divider only starts counting once the start delay has been consumed.
  assign run = (dly_reg == PH);

  always_comb begin
    cnt_next = cnt_reg;
    dly_next = dly_reg;
    clk_next = 1'b0;
    ce_next  = 1'b0;
    if (!run) begin
      dly_next = dly_reg + ONE;
    end else begin
      clk_next = (cnt_reg < HALF);
      ce_next  = (cnt_reg == '0);
      cnt_next = (cnt_reg == TERM) ? '0 : cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      cnt_reg <= '0;
      dly_reg <= '0;
      clk_reg <= 1'b0;
      ce_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      dly_reg <= dly_next;
      clk_reg <= clk_next;
      ce_reg  <= ce_next;
    end
  end

  assign clk_out = clk_reg;
  assign ce      = ce_reg;

endmodule

// File: rtl/epp_clk_gen.sv
// EPD panel clock generator: two phase-related divided clocks with strobes and a lock flag.
module epp_clk_gen
  import epp_clk_gen_pkg::*;
#(
  parameter int DIV1        = DEF_DIV,
  parameter int DIV2        = DEF_DIV,
  parameter int PHASE2      = DEF_PHASE,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CW          = DEF_CW
) (
  input  logic clk_in1,
  input  logic reset,
  output logic clk_out1,
  output logic clk_out2,
  output logic ce1,
  output logic ce2,
  output logic locked
);

  generate
    if (DIV1 < 2) begin : g_bad_div1
      $error("epp_clk_gen: DIV1 must be >= 2");
    end
    if (DIV2 < 2) begin : g_bad_div2
      $error("epp_clk_gen: DIV2 must be >= 2");
    end
    if (PHASE2 < 0 || PHASE2 >= DIV2) begin : g_bad_phase2
      $error("epp_clk_gen: PHASE2 must lie in 0..DIV2-1");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("epp_clk_gen: LOCK_CYCLES must be >= 1");
    end
    if (!fits_width(DIV1, CW) || !fits_width(DIV2, CW) || !fits_width(LOCK_CYCLES, CW)) begin : g_bad_cw
      $error("epp_clk_gen: CW too narrow for DIV1/DIV2/LOCK_CYCLES");
    end
  endgenerate

  epp_clk_div #(
    .DIV   (DIV1),
    .PHASE (0),
    .CW    (CW)
  ) u_div1 (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .clk_out (clk_out1),
    .ce      (ce1)
  );

  // XCL lags the timing-engine clock by PHASE2 input cycles via its start delay.
  epp_clk_div #(
    .DIV   (DIV2),
    .PHASE (PHASE2),
    .CW    (CW)
  ) u_div2 (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .clk_out (clk_out2),
    .ce      (ce2)
  );

  localparam logic [CW-1:0] LOCK_TERM = CW'(LOCK_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
  logic          locked_reg, locked_next;

  // Saturating count keeps locked sticky until the next reset.
  always_comb begin
    lock_cnt_next = (lock_cnt_reg == LOCK_TERM) ? lock_cnt_reg : lock_cnt_reg + ONE;
    locked_next   = locked_reg | (lock_cnt_next == LOCK_TERM);
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
      locked_reg   <= locked_next;
    end
  end

  assign locked = locked_reg;

endmodule

// File: tb/tb_epp_clk_gen.sv
// Randomised-reset bench comparing three generator configurations against a cycle-count model.
module tb_epp_clk_gen;

  logic clk;
  logic reset;

  logic d_c1, d_c2, d_e1, d_e2, d_lk;
  logic a_c1, a_c2, a_e1, a_e2, a_lk;
  logic b_c1, b_c2, b_e1, b_e2, b_lk;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  bit armed   = 1'b0;

  epp_clk_gen dut (
    .clk_in1 (clk), .reset (reset),
    .clk_out1 (d_c1), .clk_out2 (d_c2), .ce1 (d_e1), .ce2 (d_e2), .locked (d_lk)
  );

  epp_clk_gen #(.DIV1(5), .DIV2(2), .PHASE2(1), .LOCK_CYCLES(16), .CW(8)) dut_a (
    .clk_in1 (clk), .reset (reset),
    .clk_out1 (a_c1), .clk_out2 (a_c2), .ce1 (a_e1), .ce2 (a_e2), .locked (a_lk)
  );

  epp_clk_gen #(.DIV1(2), .DIV2(2), .PHASE2(0), .LOCK_CYCLES(8), .CW(8)) dut_b (
    .clk_in1 (clk), .reset (reset),
    .clk_out1 (b_c1), .clk_out2 (b_c2), .ce1 (b_e1), .ce2 (b_e2), .locked (b_lk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t = number of clock edges seen with reset low since the last reset edge.
  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  // Expected {clk_out1, ce1, clk_out2, ce2, locked} after t post-reset edges.
  function automatic logic [4:0] model(input int tt, input int d1, input int d2,
                                       input int ph, input int lk);
    int n, m;
    logic c1, e1, c2, e2, l;
    if (tt == 0) return 5'b0;
    n  = tt - 1;
    c1 = (n % d1) < (d1 / 2);
    e1 = (n % d1) == 0;
    if (n < ph) begin
      c2 = 1'b0;
      e2 = 1'b0;
    end else begin
      m  = n - ph;
      c2 = (m % d2) < (d2 / 2);
      e2 = (m % d2) == 0;
    end
    l = (tt >= lk);
    return {c1, e1, c2, e2, l};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("default", {d_c1, d_e1, d_c2, d_e2, d_lk}, model(t, 6, 6, 3, 1024));
      check("cfg_a",   {a_c1, a_e1, a_c2, a_e2, a_lk}, model(t, 5, 2, 1, 16));
      check("cfg_b",   {b_c1, b_e1, b_c2, b_e2, b_lk}, model(t, 2, 2, 0, 8));
      // Hand-derived anchors that pin the model itself.
      if (t == 0)    check("pin_reset_zero", {d_c1, d_e1, d_c2, d_e2, d_lk}, 5'b00000);
      if (t == 1)    check("pin_first_rise", {3'b000, d_c1, d_e1}, 5'b00011);
      if (t == 4)    check("pin_rise_low",   {2'b00, d_c1, d_c2, d_e2}, 5'b00011);
      if (t == 7)    check("pin_period6",    {3'b000, d_c1, d_e1}, 5'b00011);
      if (t == 2)    check("pin_a_xcl",      {3'b000, a_c2, a_e2}, 5'b00011);
      if (t == 3)    check("pin_a_low",      {4'b0000, a_c1}, 5'b00000);
      if (t == 6)    check("pin_a_period5",  {3'b000, a_c1, a_e1}, 5'b00011);
      if (t == 1023) check("pin_lock_low",   {4'b0000, d_lk}, 5'b00000);
      if (t == 1024) check("pin_lock_high",  {4'b0000, d_lk}, 5'b00001);
    end
  end

  task automatic segment(input int rst_len, input int run_len);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (rst_len) @(posedge clk);
    #1 reset = 1'b0;
    repeat (run_len) @(posedge clk);
    #1;
    $display("[TB] segment reset=%0d run=%0d tests=%0d fails=%0d", rst_len, run_len, n_tests, n_fail);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12000) @(posedge clk);
    #1;
    $display("[TB] segment reset=3 run=12000 tests=%0d fails=%0d", n_tests, n_fail);
    segment(1, 1500);
    for (int i = 0; i < 12; i++) begin
      segment(int'($urandom_range(1, 3)), int'($urandom_range(5, 200)));
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
